// File: rtl/mc_control_alu_core_if.sv
// Datapath <-> control/ALU core bundle: instruction, PC and operands in; ALU result, PC+4 and control lines out.
// master = surrounding datapath, slave = the core.
interface mc_control_alu_core_if;
  logic [31:0] instr;
  logic [31:0] pcQ;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;
  logic [31:0] pcPlus4;
  logic [4:0]  ALUControl;
  logic        alu4, alu3, alu2, alu1, alu0;
  logic        memToReg, memWrite, branchEnable, ALUSrc, regDst, regWriteEnable, jump, jumpReg;
  logic        PCWrite, IorD, IRWrite, ALUSrcA, secondRound;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSrc;

  modport master (
    output instr, pcQ, SrcA, SrcB,
    input  ALUResult, pcPlus4, ALUControl, alu4, alu3, alu2, alu1, alu0,
    input  memToReg, memWrite, branchEnable, ALUSrc, regDst, regWriteEnable, jump, jumpReg,
    input  PCWrite, IorD, IRWrite, ALUSrcA, secondRound, ALUSrcB, PCSrc
  );

  modport slave (
    input  instr, pcQ, SrcA, SrcB,
    output ALUResult, pcPlus4, ALUControl, alu4, alu3, alu2, alu1, alu0,
    output memToReg, memWrite, branchEnable, ALUSrc, regDst, regWriteEnable, jump, jumpReg,
    output PCWrite, IorD, IRWrite, ALUSrcA, secondRound, ALUSrcB, PCSrc
  );
endinterface

// File: rtl/mc_control_alu_core.sv
// Multicycle MIPS-subset control FSM + 32-bit ALU + PC+4 adder; outputs combinational from state/instr.
// Most instructions take one cycle, lw/sw two; no backpressure, datapath follows the control lines.
module mc_control_alu_core (
  input  logic                 clock,
  input  logic                 reset,
  mc_control_alu_core_if.slave bus
);

  typedef enum logic [1:0] {FETCH, LW_MEM, SW_MEM} state_t;

  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_SLT = 5'b00111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BLT   = 6'h04;
  localparam logic [5:0] OP_NORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t     state;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] alu_ctl;

  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (opcode == OP_LW)      state <= LW_MEM;
          else if (opcode == OP_SW) state <= SW_MEM;
          else                      state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    alu_ctl            = ALU_ADD;
    bus.memToReg       = 1'b0;
    bus.memWrite       = 1'b0;
    bus.branchEnable   = 1'b0;
    bus.ALUSrc         = 1'b0;
    bus.regDst         = 1'b0;
    bus.regWriteEnable = 1'b0;
    bus.jump           = 1'b0;
    bus.jumpReg        = 1'b0;
    bus.PCWrite        = 1'b0;
    bus.IorD           = 1'b0;
    bus.IRWrite        = 1'b0;
    bus.ALUSrcA        = 1'b0;
    bus.secondRound    = 1'b0;
    bus.ALUSrcB        = 2'b00;
    bus.PCSrc          = 2'b00;

    if (state == LW_MEM || state == SW_MEM) begin
      // Memory round: address = base + SignImm, then advance PC; instr is ignored here.
      bus.secondRound = 1'b1;
      bus.IorD        = 1'b1;
      bus.ALUSrcB     = 2'b10;
      bus.ALUSrc      = 1'b1;
      bus.PCWrite     = 1'b1;
      if (state == LW_MEM) begin
        bus.memToReg       = 1'b1;
        bus.regWriteEnable = 1'b1;
      end else begin
        bus.memWrite = 1'b1;
      end
    end else begin
      bus.IRWrite = 1'b1;
      bus.PCWrite = 1'b1;
      case (opcode)
        OP_LW, OP_SW: bus.PCWrite = 1'b0;
        OP_RTYPE: begin
          case (funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: begin
              bus.regDst         = 1'b1;
              bus.regWriteEnable = 1'b1;
              case (funct)
                6'h22:   alu_ctl = ALU_SUB;
                6'h24:   alu_ctl = ALU_AND;
                6'h25:   alu_ctl = ALU_OR;
                6'h27:   alu_ctl = ALU_NOR;
                6'h2A:   alu_ctl = ALU_SLT;
                default: alu_ctl = ALU_ADD;
              endcase
            end
            6'h08: begin
              bus.jumpReg = 1'b1;
              bus.PCSrc   = 2'b01;
            end
            default: ;
          endcase
        end
        OP_J: begin
          bus.jump  = 1'b1;
          bus.PCSrc = 2'b01;
        end
        OP_JAL: begin
          bus.jump           = 1'b1;
          bus.PCSrc          = 2'b01;
          bus.regWriteEnable = 1'b1;
        end
        OP_BLT: begin
          bus.branchEnable = 1'b1;
          alu_ctl          = ALU_SUB;
          bus.PCSrc        = 2'b10;
        end
        OP_NORI: begin
          alu_ctl            = ALU_NOR;
          bus.ALUSrc         = 1'b1;
          bus.ALUSrcB        = 2'b10;
          bus.regWriteEnable = 1'b1;
        end
        default: ;
      endcase
    end

    // Reset only suppresses state-changing strobes; everything else keeps decoding.
    if (reset) begin
      bus.PCWrite        = 1'b0;
      bus.IRWrite        = 1'b0;
      bus.memWrite       = 1'b0;
      bus.regWriteEnable = 1'b0;
    end
  end

  assign bus.ALUControl = alu_ctl;
  assign bus.alu4       = alu_ctl[4];
  assign bus.alu3       = alu_ctl[3];
  assign bus.alu2       = alu_ctl[2];
  assign bus.alu1       = alu_ctl[1];
  assign bus.alu0       = alu_ctl[0];

  always_comb begin
    case (alu_ctl)
      ALU_ADD: bus.ALUResult = bus.SrcA + bus.SrcB;
      ALU_SUB: bus.ALUResult = bus.SrcA - bus.SrcB;
      ALU_AND: bus.ALUResult = bus.SrcA & bus.SrcB;
      ALU_OR:  bus.ALUResult = bus.SrcA | bus.SrcB;
      ALU_NOR: bus.ALUResult = ~(bus.SrcA | bus.SrcB);
      ALU_SLT: bus.ALUResult = {31'd0, $signed(bus.SrcA) < $signed(bus.SrcB)};
      default: bus.ALUResult = 32'd0;
    endcase
  end

  assign bus.pcPlus4 = bus.pcQ + 32'd4;

endmodule

// File: tb/tb_mc_control_alu_core.sv
// Directed test-plan steps followed by random instructions/operands, all checked against an in-bench reference model.
module tb_mc_control_alu_core;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mc_control_alu_core_if bus();

  mc_control_alu_core dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] alu;
    logic       memToReg, memWrite, branchEnable, ALUSrc, regDst, regWriteEnable, jump, jumpReg;
    logic       PCWrite, IorD, IRWrite, ALUSrcA, secondRound;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
  } ctrl_t;

  // Reference-model memory round: which access (if any) the previous fetch started.
  bit pend_load  = 1'b0;
  bit pend_store = 1'b0;

  function automatic logic [31:0] mk_r(input logic [5:0] fn);
    return {6'h00, 20'($urandom), fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op);
    return {op, 26'($urandom)};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      5'b00010: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      5'b00110: return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b01100: return 32'hFFFF_FFFF ^ (a | b);
      5'b00111: return (sa < sb) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic ctrl_t model_ctrl(input logic [31:0] ins, input bit ld, input bit st, input bit rst);
    ctrl_t c;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    c = '0;
    c.alu = 5'b00010;
    if (ld || st) begin
      c.secondRound = 1; c.IorD = 1; c.ALUSrcB = 2'b10; c.ALUSrc = 1; c.PCWrite = 1;
      c.memToReg = ld; c.regWriteEnable = ld; c.memWrite = st;
    end else begin
      c.IRWrite = 1;
      c.PCWrite = !(op == 6'h23 || op == 6'h2B);
      if (op == 6'h00) begin
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A}) begin
          c.regDst = 1; c.regWriteEnable = 1;
          c.alu = (fn == 6'h22) ? 5'b00110 : (fn == 6'h24) ? 5'b00000 : (fn == 6'h25) ? 5'b00001 :
                  (fn == 6'h27) ? 5'b01100 : (fn == 6'h2A) ? 5'b00111 : 5'b00010;
        end else if (fn == 6'h08) begin
          c.jumpReg = 1; c.PCSrc = 2'b01;
        end
      end else if (op == 6'h02 || op == 6'h03) begin
        c.jump = 1; c.PCSrc = 2'b01; c.regWriteEnable = (op == 6'h03);
      end else if (op == 6'h04) begin
        c.branchEnable = 1; c.alu = 5'b00110; c.PCSrc = 2'b10;
      end else if (op == 6'h0E) begin
        c.alu = 5'b01100; c.ALUSrc = 1; c.ALUSrcB = 2'b10; c.regWriteEnable = 1;
      end
    end
    if (rst) begin
      c.PCWrite = 0; c.IRWrite = 0; c.memWrite = 0; c.regWriteEnable = 0;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic rst);
    bus.instr = ins;
    bus.SrcA  = a;
    bus.SrcB  = b;
    bus.pcQ   = pc;
    reset     = rst;
    #2;
  endtask

  task automatic verify(input string tag);
    ctrl_t exp, obs;
    exp = model_ctrl(bus.instr, pend_load, pend_store, reset);
    obs = {bus.ALUControl, bus.memToReg, bus.memWrite, bus.branchEnable, bus.ALUSrc, bus.regDst,
           bus.regWriteEnable, bus.jump, bus.jumpReg, bus.PCWrite, bus.IorD, bus.IRWrite,
           bus.ALUSrcA, bus.secondRound, bus.ALUSrcB, bus.PCSrc};
    check({tag, ".ctrl"}, 32'(obs), 32'(exp));
    check({tag, ".aluN"}, 32'({bus.alu4, bus.alu3, bus.alu2, bus.alu1, bus.alu0}), 32'(exp.alu));
    check({tag, ".ALUResult"}, bus.ALUResult, alu_ref(exp.alu, bus.SrcA, bus.SrcB));
    check({tag, ".pcPlus4"}, bus.pcPlus4, 32'((64'(bus.pcQ) + 64'd4) % 64'h1_0000_0000));
  endtask

  task automatic tick();
    bit nl, ns, in_fetch;
    in_fetch = !(pend_load || pend_store);
    nl = !reset && in_fetch && (bus.instr[31:26] == 6'h23);
    ns = !reset && in_fetch && (bus.instr[31:26] == 6'h2B);
    @(posedge clock);
    pend_load  = nl;
    pend_store = ns;
    #1;
  endtask

  logic [31:0] tab_ins [5];
  logic [1:0]  tab_pcsrc [5];
  logic        tab_regdst [5], tab_jump [5], tab_jr [5], tab_rwe [5];
  logic [5:0]  rfun [8];
  logic [31:0] ins;

  initial begin
    // Reset held two cycles with lw on the bus.
    apply(mk_i(6'h23), 32'd1, 32'd2, 32'd0, 1'b1);
    tick();
    apply(mk_i(6'h23), 32'd1, 32'd2, 32'd0, 1'b1);
    verify("reset");
    check("reset.IRWrite", 32'(bus.IRWrite), 32'd0);
    check("reset.PCWrite", 32'(bus.PCWrite), 32'd0);
    check("reset.memWrite", 32'(bus.memWrite), 32'd0);
    check("reset.regWriteEnable", 32'(bus.regWriteEnable), 32'd0);
    tick();

    // lw: fetch round, memory round, back in fetch.
    apply(mk_i(6'h23), 32'h100, 32'h8, 32'h40, 1'b0);
    verify("lw1");
    check("lw1.IRWrite", 32'(bus.IRWrite), 32'd1);
    check("lw1.PCWrite", 32'(bus.PCWrite), 32'd0);
    check("lw1.secondRound", 32'(bus.secondRound), 32'd0);
    tick();
    apply(mk_r(6'h22), 32'h100, 32'h8, 32'h40, 1'b0);
    verify("lw2");
    check("lw2.secondRound", 32'(bus.secondRound), 32'd1);
    check("lw2.IorD", 32'(bus.IorD), 32'd1);
    check("lw2.memToReg", 32'(bus.memToReg), 32'd1);
    check("lw2.regWriteEnable", 32'(bus.regWriteEnable), 32'd1);
    check("lw2.PCWrite", 32'(bus.PCWrite), 32'd1);
    check("lw2.ALUSrcB", 32'(bus.ALUSrcB), 32'd2);
    check("lw2.ALUResult", bus.ALUResult, 32'h108);
    tick();

    // ALU and PC+4 directed values.
    apply(mk_r(6'h20), 32'd5, 32'd7, 32'h10, 1'b0);
    verify("add");
    check("lw3.secondRound", 32'(bus.secondRound), 32'd0);
    check("add.ALUResult", bus.ALUResult, 32'd12);
    check("add.pcPlus4", bus.pcPlus4, 32'h14);
    tick();
    apply(mk_r(6'h22), 32'd5, 32'd7, 32'h10, 1'b0);
    verify("sub");
    check("sub.ALUResult", bus.ALUResult, 32'hFFFF_FFFE);
    tick();
    apply(mk_r(6'h2A), 32'd5, 32'd7, 32'h10, 1'b0);
    verify("slt");
    check("slt.ALUResult", bus.ALUResult, 32'd1);
    tick();
    apply(mk_r(6'h20), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 1'b0);
    verify("addwrap");
    check("addwrap.ALUResult", bus.ALUResult, 32'd0);
    check("pcwrap.pcPlus4", bus.pcPlus4, 32'd0);
    tick();
    apply(mk_r(6'h27), 32'd0, 32'd0, 32'h20, 1'b0);
    verify("nor");
    check("nor.ALUResult", bus.ALUResult, 32'hFFFF_FFFF);
    tick();

    // sw aborted by reset during its memory round.
    apply(mk_i(6'h2B), 32'h200, 32'h4, 32'h30, 1'b0);
    verify("sw1");
    tick();
    apply(mk_i(6'h2B), 32'h200, 32'h4, 32'h30, 1'b1);
    verify("swrst");
    check("swrst.memWrite", 32'(bus.memWrite), 32'd0);
    check("swrst.secondRound", 32'(bus.secondRound), 32'd1);
    tick();
    apply(mk_r(6'h25), 32'hF0, 32'h0F, 32'h34, 1'b0);
    verify("swrst_next");
    check("swrst_next.secondRound", 32'(bus.secondRound), 32'd0);
    check("swrst_next.or", bus.ALUResult, 32'hFF);
    tick();

    // Single-cycle control table: add, jal, jr, blt, nori.
    tab_ins    = '{mk_r(6'h20), mk_i(6'h03), mk_r(6'h08), mk_i(6'h04), mk_i(6'h0E)};
    tab_pcsrc  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    tab_regdst = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tab_jump   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tab_jr     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab_rwe    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apply(tab_ins[i], 32'($urandom), 32'($urandom), 32'($urandom), 1'b0);
      verify($sformatf("tab%0d", i));
      check($sformatf("tab%0d.PCSrc", i), 32'(bus.PCSrc), 32'(tab_pcsrc[i]));
      check($sformatf("tab%0d.regDst", i), 32'(bus.regDst), 32'(tab_regdst[i]));
      check($sformatf("tab%0d.jump", i), 32'(bus.jump), 32'(tab_jump[i]));
      check($sformatf("tab%0d.jumpReg", i), 32'(bus.jumpReg), 32'(tab_jr[i]));
      check($sformatf("tab%0d.regWriteEnable", i), 32'(bus.regWriteEnable), 32'(tab_rwe[i]));
      check($sformatf("tab%0d.secondRound", i), 32'(bus.secondRound), 32'd0);
      tick();
    end

    // Random instruction mix, operands and occasional reset.
    rfun = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h08, 6'h3F};
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       ins = mk_i(6'h23);
        1:       ins = mk_i(6'h2B);
        2, 3:    ins = mk_r(rfun[$urandom_range(0, 7)]);
        4:       ins = mk_i(6'h02);
        5:       ins = mk_i(6'h03);
        6:       ins = mk_i(6'h04);
        7:       ins = mk_i(6'h0E);
        8:       ins = mk_r(6'($urandom));
        default: ins = mk_i(6'($urandom));
      endcase
      apply(ins, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom),
            32'($urandom), ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom),
            ($urandom_range(0, 15) == 0));
      verify($sformatf("rnd%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
